// File: rtl/slurm16_uart_tx_responder_if.sv
// slurm16 CPU memory-bus signals seen by a memory-mapped responder.
interface slurm16_uart_tx_responder_if;
  logic [15:0] ADDRESS;
  logic [15:0] DATA_IN;
  logic [15:0] DATA_OUT;
  logic        DATA_OE;
  logic        OEb;
  logic        WRb;

  modport master (
    output ADDRESS, DATA_IN, OEb, WRb,
    input  DATA_OUT, DATA_OE
  );

  modport slave (
    input  ADDRESS, DATA_IN, OEb, WRb,
    output DATA_OUT, DATA_OE
  );
endinterface

// File: rtl/slurm16_uart_tx_responder.sv
// slurm16 memory-bus UART transmitter: TX FIFO plus 8N1 serialiser with
// programmable bit rate. Register window of 4 words at BASE_ADDR.
// Optional interrupt output enabled by defining UART_TX_IRQ_EN.
module slurm16_uart_tx_responder #(
  parameter logic [15:0] BASE_ADDR      = 16'hFF00,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter logic [15:0] BAUD_DIV_RESET = 16'd433
) (
  input  logic                         CLK,
  input  logic                         RST,
  slurm16_uart_tx_responder_if.slave   bus,
  output logic                         TX,
  output logic                         IRQ
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [15:0]       bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              pop_c;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic [15:0]       baud_div_q;
  logic              overflow_q;
  logic              irq_en_q;
  logic [15:0]       data_out_q;
  logic              data_oe_q;

  logic              hit_c, wr_c, rd_c;
  logic [1:0]        offset_c;
  logic              empty_c, full_c, busy_c;
  logic              push_req_c, push_c, drop_c;
  logic [15:0]       status_c, rd_data_c;

  assign hit_c      = (bus.ADDRESS[15:2] == BASE_ADDR[15:2]);
  assign offset_c   = bus.ADDRESS[1:0];
  assign wr_c       = hit_c && !bus.WRb;
  assign rd_c       = hit_c && !bus.OEb && bus.WRb;

  assign empty_c    = (count_q == '0);
  assign full_c     = (count_q == CNT_W'(FIFO_DEPTH));
  assign busy_c     = (state_q != S_IDLE);

  // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
  assign push_req_c = wr_c && (offset_c == 2'd0);
  assign push_c     = push_req_c && (!full_c || pop_c);
  assign drop_c     = push_req_c && !push_c;

  assign status_c   = {7'b0, irq_en_q, 4'b0, overflow_q, busy_c, full_c, empty_c};

  // Read-data selection; TXDATA is write-only.
  always_comb begin
    rd_data_c = 16'h0000;
    case (offset_c)
      2'd1:    rd_data_c = status_c;
      2'd2:    rd_data_c = baud_div_q;
      default: rd_data_c = 16'h0000;
    endcase
  end

  // Serialiser next-state: each bit lasts bit_cnt reload value + 1 clocks.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    bit_cnt_d = bit_cnt_q;
    pop_c     = 1'b0;
    tx_d      = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!empty_c) begin
          pop_c     = 1'b1;
          shift_d   = mem[rd_ptr_q];
          bit_cnt_d = baud_div_q;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_cnt_q == 16'd0) begin
          bit_cnt_d = baud_div_q;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = 16'(bit_cnt_q - 16'd1);
        end
      end
      S_DATA: begin
        if (bit_cnt_q == 16'd0) begin
          bit_cnt_d = baud_div_q;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = 3'(bit_idx_q + 3'd1);
          end
        end else begin
          bit_cnt_d = 16'(bit_cnt_q - 16'd1);
        end
      end
      S_STOP: begin
        if (bit_cnt_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          bit_cnt_d = 16'(bit_cnt_q - 16'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Line level follows the state being entered so TX stays registered.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Serialiser state register; reset forces the line idle immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      bit_cnt_q <= 16'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

  // FIFO storage, no reset needed since count gates every read.
  always_ff @(posedge CLK) begin
    if (push_c) mem[wr_ptr_q] <= bus.DATA_IN[7:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= PTR_W'(wr_ptr_q + PTR_W'(1));
      if (pop_c)  rd_ptr_q <= PTR_W'(rd_ptr_q + PTR_W'(1));
      count_q <= CNT_W'(count_q + CNT_W'(push_c) - CNT_W'(pop_c));
    end
  end

  // Control registers written over the bus.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      baud_div_q <= BAUD_DIV_RESET;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      if (drop_c) begin
        overflow_q <= 1'b1;
      end else if (wr_c && (offset_c == 2'd1) && bus.DATA_IN[3]) begin
        overflow_q <= 1'b0;
      end
      if (wr_c && (offset_c == 2'd1)) irq_en_q   <= bus.DATA_IN[8];
      if (wr_c && (offset_c == 2'd2)) baud_div_q <= bus.DATA_IN;
    end
  end

  // Registered read port with one cycle of latency; data holds between reads.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_out_q <= 16'h0000;
      data_oe_q  <= 1'b0;
    end else begin
      data_oe_q <= rd_c;
      if (rd_c) data_out_q <= rd_data_c;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_q;

  // Interrupt when enabled and the transmitter has fully drained.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) irq_q <= 1'b0;
    else     irq_q <= irq_en_q && empty_c && !busy_c;
  end

  assign IRQ = irq_q;
`else
  assign IRQ = 1'b0;
`endif

  assign TX           = tx_q;
  assign bus.DATA_OUT = data_out_q;
  assign bus.DATA_OE  = data_oe_q;

endmodule

// File: doc/slurm16_uart_tx_responder.md
Name: slurm16_uart_tx_responder

Overview:
- Memory-mapped bus responder on the slurm16 memory bus, sitting beside the memory controller at a fixed address window.
- Accepts CPU writes of bytes into a small TX FIFO and serialises them as 8N1 UART frames at a programmable bit rate.
- Answers CPU reads with status and divider registers; it is the target-side end of the CPU's ADDRESS/DATA/OEb/WRb interface.

Parameters:
- BASE_ADDR, 16'hFF00, window base; the block decodes 4 words at BASE_ADDR[15:2].
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, minimum 2.
- BAUD_DIV_RESET, 16'd433, reset value of the BAUD_DIV register.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ADDRESS  in  16  CPU bus address.
- DATA_IN  in  16  CPU write data.
- DATA_OUT  out  16  read data, registered.
- DATA_OE  out  1  high while DATA_OUT is driving the bus, registered.
- OEb  in  1  read strobe, active low.
- WRb  in  1  write strobe, active low.
- TX  out  1  UART serial output; idles high.
- IRQ  out  1  interrupt request (see Optional Feature).

Behaviour:
- Reset (async, while RST=1): TX=1, DATA_OUT=0, DATA_OE=0, IRQ=0, FIFO empty, FSM=IDLE, overflow=0, irq_en=0, BAUD_DIV=BAUD_DIV_RESET. Asserting RST mid-frame aborts the frame and forces TX high immediately.
- Decode: hit = (ADDRESS[15:2]==BASE_ADDR[15:2]); offset = ADDRESS[1:0].
- Write: if hit and WRb=0 at a rising edge, one write happens per clock with WRb low.
  - Offset 0 (TXDATA): push DATA_IN[7:0] into the FIFO. If the FIFO is full and no pop occurs this cycle, drop the byte and set overflow.
  - Offset 1 (STATUS): writing 1 to bit3 clears overflow. Bit8 is written into irq_en.
  - Offset 2 (BAUD_DIV): load the 16-bit value.
  - Offset 3: ignored.
- Read: if hit, OEb=0, WRb=1 at an edge, then DATA_OE=1 next cycle and DATA_OUT is loaded with the selected register. Otherwise DATA_OE=0 and DATA_OUT holds. One cycle of read latency.
  - STATUS = {7'b0, irq_en, 4'b0, overflow, busy, full, empty}.
  - TXDATA reads 0 (write-only). BAUD_DIV reads back its value. Offset 3 reads 0.
- Simultaneous push and pop while full: pop first, push accepted, count unchanged, no overflow.
- FIFO: circular, pointers of log2(FIFO_DEPTH) bits that wrap; count is 0..FIFO_DEPTH. empty = (count==0); full = (count==FIFO_DEPTH).
- Bit timer: each bit lasts BAUD_DIV+1 clocks, so BAUD_DIV=0 gives 1 clock per bit. The counter reloads from BAUD_DIV at every bit boundary, so a mid-frame BAUD_DIV write takes effect at the next bit.
- FSM, with busy = (state != IDLE):
  - IDLE: TX=1. If not empty: pop the byte into the shift register and go to START. The first TX=0 appears the cycle after the pop.
  - START: TX=0 for one bit time, then go to DATA with bit index 0.
  - DATA: TX=shift[0], LSB first. After each bit time, shift right and increment the index. After index 7, go to STOP.
  - STOP: TX=1 for one bit time, then go to IDLE. If the FIFO is non-empty, the next frame starts without an extra idle bit: the pop occurs in the IDLE cycle, so there is at most 1 clock of idle gap.
- Frame length: 10 bit times plus 1 clock of IDLE pop.

Optional Feature:
- Macro UART_TX_IRQ_EN.
- Defined: IRQ is registered, IRQ = irq_en & empty & ~busy. It asserts 1 clock after the frame's STOP completes with the FIFO empty, and clears when a byte is pushed or irq_en is cleared.
- Undefined: IRQ is tied to 0. irq_en remains a readable/writable STATUS bit with no effect.

Test Plan:
- Reset, then read STATUS at 16'hFF01 -> next cycle DATA_OE=1, DATA_OUT=16'h0001; TX=1.
- Write BAUD_DIV=3 at 16'hFF02, then write 16'h00A5 to 16'hFF00 -> TX shows start 0, bits 1,0,1,0,0,1,0,1, stop 1. Each bit is exactly 4 clocks; STATUS busy=1 during the frame.
- Write 9 bytes back-to-back with BAUD_DIV=0 and FIFO_DEPTH=8 -> the first is popped immediately, so all 9 are accepted and overflow=0. With 10 writes, overflow=1 (STATUS=16'h000E while full and busy). Writing 16'h0008 to STATUS clears overflow.
- Assert RST during DATA bit 3 -> TX=1 in the same cycle without waiting for a clock; after release, STATUS=16'h0001 and BAUD_DIV reads 433.
- Write BAUD_DIV from 3 to 7 during data bit 2 -> bit 2 still lasts 4 clocks; bits 3..7 and stop last 8 clocks each.
- UART_TX_IRQ_EN defined: write STATUS=16'h0100, send one byte -> IRQ=0 during the frame and IRQ=1 one clock after STOP ends. A write to TXDATA drops IRQ the next cycle.
